// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the
// queued instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned PC_STEP_DEF  = 1;
  localparam int          XLEN_DEF     = 32;
  localparam int          ILEN_DEF     = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] ir;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with
// push/pop/clear and an occupancy count.
module sync_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push &&
    ((count != CW'(DEPTH)) || do_pop);

  // An empty queue presents zeros, not stale storage.
  assign rdata = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential PC generator, imem credit
// tracking and redirect flush in front of a fetch FIFO.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int          XLEN            = 32,
  parameter  int          ILEN            = 32,
  parameter  int          DEPTH           = 4,
  parameter  int          MAX_OUTSTANDING = 2,
  parameter  int unsigned PC_STEP         = PC_STEP_DEF,
  parameter  int unsigned RESET_PC        = RESET_PC_DEF,
  localparam int          CW = $clog2(DEPTH) + 1,
  localparam int          OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_ir,
  output logic [XLEN-1:0] id_pc,
  output logic [CW-1:0]   count
);

  localparam int SW = ((CW > OW) ? CW : OW) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [OW-1:0]   out_next;
  logic [OW-1:0]   drop_next;
  logic            req_hs;
  logic            resp_ok;
  logic            push;
  logic            pop;
  entry_t          wentry;
  entry_t          hentry;

  // Credit: every accepted request owns a FIFO slot.
  assign imem_req_valid = rst && !redirect &&
    (outstanding < OW'(MAX_OUTSTANDING)) &&
    ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));

  assign imem_req_addr = pc_q;
  assign req_hs   = imem_req_valid && imem_req_ready;
  assign resp_ok  = imem_resp_valid && (outstanding != '0);
  assign push     = resp_ok && (drop_cnt == '0) && !redirect;
  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready && !redirect;
  assign wentry   = '{pc: resp_pc, ir: imem_resp_data};
  assign id_pc    = hentry.pc;
  assign id_ir    = hentry.ir;

  always_comb begin
    out_next  = outstanding + OW'(req_hs) - OW'(resp_ok);
    drop_next = drop_cnt;
    if (redirect)
      drop_next = out_next;
    else if (resp_ok && (drop_cnt != '0))
      drop_next = drop_cnt - OW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc_q        <= XLEN'(RESET_PC);
      resp_pc     <= XLEN'(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      drop_cnt    <= drop_next;
      state       <= (drop_next != '0) ? FLUSH : FETCH;
      if (redirect) begin
        pc_q    <= redirect_pc;
        resp_pc <= redirect_pc;
      end else begin
        if (req_hs) pc_q    <= pc_q + STEP;
        if (push)   resp_pc <= resp_pc + STEP;
      end
    end
  end

  sync_fifo #(
    .W     (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata (wentry),
    .rdata (hentry),
    .count (count)
  );

  resp_needs_req: assert property (
    @(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (outstanding != '0));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-register PC / IFID pairing.
- Generates sequential PCs and issues requests to a pipelined instruction memory with a valid/ready handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- A branch redirect flushes the queue and discards in-flight responses, so decode never sees wrong-path instructions.

Parameters:
- XLEN, 32, PC/address width.
- ILEN, 32, instruction width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests (>=1).
- PC_STEP, 1, PC increment per instruction (word-addressed default).
- RESET_PC, 0, PC after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address.
- imem_resp_valid  input  1  instruction returned; in order, may arrive 1+ cycles after acceptance.
- imem_resp_data  input  ILEN  returned instruction.
- redirect  input  1  branch taken / flush (one cycle).
- redirect_pc  input  XLEN  new fetch PC.
- id_valid  output  1  head entry valid to decode.
- id_ready  input  1  decode accepts (low = stall).
- id_ir  output  ILEN  head instruction.
- id_pc  output  XLEN  head PC.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset (rst=0, asynchronous):
- pc_q=RESET_PC; FIFO pointers, count, outstanding and drop_cnt all 0; state=FETCH.
- imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_ir=0, id_pc=0.
- Reset asserted mid-operation discards all queue contents and in-flight bookkeeping; responses that arrive after reset release are not counted and are ignored.

Request issue:
- imem_req_valid = !redirect && (outstanding < MAX_OUTSTANDING) && (count + outstanding < DEPTH). This credit rule guarantees every accepted response has a FIFO slot.
- imem_req_addr = pc_q.
- On handshake: pc_q += PC_STEP (mod 2^XLEN) and outstanding increments.

Response handling:
- If drop_cnt > 0, the response is discarded and drop_cnt decrements.
- Otherwise {pc, ir} is pushed. The entry PC is tracked by a separate response-PC register that advances by PC_STEP per accepted response.
- A response arriving when outstanding=0 is an error (simulation assertion) and is ignored.

Dequeue:
- id_valid = (count != 0); id_ir and id_pc come from the head entry and are combinational from FIFO storage.
- Pop on id_valid && id_ready.
- Push and pop in the same cycle leave count unchanged and are legal at full or empty.
- Pointers wrap modulo DEPTH.

Redirect (highest priority):
- In the cycle redirect=1: no request issues, any push and pop that cycle are suppressed, and id_valid is still shown but the pop is ignored.
- At the clock edge: FIFO cleared (count=0); pc_q and resp_pc both set to redirect_pc.
- drop_cnt = outstanding − (imem_resp_valid ? 1 : 0) + drop_cnt-carry; effectively every outstanding response is dropped.
- Fetch from redirect_pc starts the following cycle.
- Back-to-back redirects: the latest redirect_pc wins and drop_cnt accumulates correctly.

FSM:
- FETCH: drop_cnt=0. Moves to FLUSH on redirect with outstanding>0 (after accounting for a response arriving that same cycle).
- FLUSH: drop_cnt>0. New requests may still issue. Returns to FETCH when the last stale response is dropped.

Outstanding counter:
- Increments on request handshake, decrements on any response; both in one cycle leave it unchanged.

Decomposition:
- Shared package fetch_pkg holds: the fetch_entry_t struct {pc, ir}, the state enum {FETCH, FLUSH}, and the RESET_PC/PC_STEP defaults.
- One natural sub-module, sync_fifo, parametrised on width and DEPTH, with push/pop/clear/count and async active-low reset.
- fetch_queue contains the PC, credit, drop and FSM logic.

Test Plan:
1. Reset release, imem 1-cycle latency, id_ready=1 -> imem_req_addr sequence 0,1,2,3…; id_pc 0,1,2 with matching id_ir; count stays ≤2.
2. id_ready=0 for 10 cycles -> count reaches 4 (DEPTH) and no further requests issue. Then id_ready=1 -> entries 0..3 dequeue in order and fetch resumes at 4.
3. Two requests outstanding (addr 5, 6), redirect to 0x40 -> both stale responses dropped, state FLUSH→FETCH, next id_pc=0x40, no id_pc 5/6 seen.
4. Redirect coincident with a response and a pop -> response dropped, count=0 next cycle, drop_cnt=outstanding−1, first new entry pc=redirect_pc.
5. Continuous streaming for 3×DEPTH entries with random id_ready -> pointer wrap-around is correct, no loss or duplication, imem_resp_valid never arrives when full.
6. rst asserted mid-stream with 2 outstanding -> outputs at reset values immediately (asynchronous), fetch restarts at RESET_PC, and stray late responses are ignored.
